// File: rtl/ita_package.sv
// Shared types for the ITA output writer: job configuration record and control FSM states.
package ita_package;

    localparam int unsigned OUP_CFG_AW = 32;

    typedef struct packed {
        logic [OUP_CFG_AW-1:0] base_addr;
        logic [OUP_CFG_AW-1:0] row_stride;
        logic [15:0]           tile_rows;
        logic [15:0]           tiles_col;
        logic [15:0]           tiles_row;
    } oup_writer_cfg_t;

    typedef enum logic {
        OW_IDLE = 1'b0,
        OW_RUN  = 1'b1
    } oup_writer_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO; with FALL_THROUGH=0 a pushed word reaches data_o one cycle later.
// Pushes while full and pops while empty are dropped; push and pop may coincide.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]        cnt_q;
    logic                  is_empty, bypass, push_en, pop_en;

    assign is_empty = (cnt_q == '0);
    assign full_o   = (cnt_q == FULL_CNT);
    // In fall-through mode a word pushed and popped into an empty FIFO never gets stored.
    assign bypass   = FALL_THROUGH && is_empty && push_i && pop_i;
    assign empty_o  = is_empty && !(FALL_THROUGH && push_i);
    assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];
    assign push_en  = push_i && !full_o && !bypass;
    assign pop_en   = pop_i && !is_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ita_oup_addr_gen.sv
// Byte-address generator walking rows (inner), tile columns, tile rows (outer); advances on adv_i.
// Address is built from running offsets so no multipliers are needed.
module ita_oup_addr_gen
    import ita_package::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned WI = 8,
    parameter int unsigned AW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  oup_writer_cfg_t cfg_i,
    input  logic            adv_i,
    output logic [AW-1:0]   addr_o,
    output logic            last_o
);
    localparam logic [AW-1:0] COL_STEP = AW'(N * WI / 8);

    logic [AW-1:0] base_q, stride_q, tile_base_q, col_off_q, row_off_q;
    logic [15:0]   rows_q, cols_q, trows_q, r_q, c_q, t_q;
    logic          r_last, c_last, t_last;

    assign r_last = (r_q == rows_q - 16'd1);
    assign c_last = (c_q == cols_q - 16'd1);
    assign t_last = (t_q == trows_q - 16'd1);
    assign last_o = r_last && c_last && t_last;
    assign addr_o = tile_base_q + col_off_q + row_off_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q      <= '0;
            stride_q    <= '0;
            tile_base_q <= '0;
            col_off_q   <= '0;
            row_off_q   <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            trows_q     <= '0;
            r_q         <= '0;
            c_q         <= '0;
            t_q         <= '0;
        end else if (load_i) begin
            base_q      <= AW'(cfg_i.base_addr);
            stride_q    <= AW'(cfg_i.row_stride);
            tile_base_q <= AW'(cfg_i.base_addr);
            col_off_q   <= '0;
            row_off_q   <= '0;
            rows_q      <= cfg_i.tile_rows;
            cols_q      <= cfg_i.tiles_col;
            trows_q     <= cfg_i.tiles_row;
            r_q         <= '0;
            c_q         <= '0;
            t_q         <= '0;
        end else if (adv_i) begin
            if (!r_last) begin
                r_q       <= r_q + 16'd1;
                row_off_q <= row_off_q + stride_q;
            end else begin
                r_q       <= '0;
                row_off_q <= '0;
                if (!c_last) begin
                    c_q       <= c_q + 16'd1;
                    col_off_q <= col_off_q + COL_STEP;
                end else begin
                    c_q       <= '0;
                    col_off_q <= '0;
                    // Next tile row starts tile_rows strides further: last row offset plus one stride.
                    if (!t_last) begin
                        t_q         <= t_q + 16'd1;
                        tile_base_q <= tile_base_q + row_off_q + stride_q;
                    end else begin
                        t_q         <= '0;
                        tile_base_q <= base_q;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ita_oup_writer.sv
// Streams ITA output beats into memory writes through a 2-deep buffer; beat-to-request latency 1.
// oup_ready_o drops when the buffer is full, the job is idle, or all beats of the job were taken.
module ita_oup_writer
    import ita_package::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned WI = 8,
    parameter int unsigned AW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  oup_writer_cfg_t cfg_i,
    output logic            busy_o,
    output logic            done_o,
    input  logic            oup_valid_i,
    output logic            oup_ready_o,
    input  logic [N*WI-1:0] oup_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic [N*WI-1:0] mem_wdata_o
);
    oup_writer_state_e state_q, state_d;
    logic              done_q, done_d;
    logic [47:0]       total_q, acc_cnt_q;
    logic              fifo_full, fifo_empty, push, pop, last_beat, job_empty, load;

    assign job_empty   = (cfg_i.tile_rows == '0) || (cfg_i.tiles_col == '0) || (cfg_i.tiles_row == '0);
    assign load        = (state_q == OW_IDLE) && start_i;
    assign oup_ready_o = (state_q == OW_RUN) && !fifo_full && (acc_cnt_q != total_q);
    assign push        = oup_valid_i && oup_ready_o;
    assign mem_req_o   = !fifo_empty;
    assign pop         = mem_req_o && mem_gnt_i;
    assign busy_o      = (state_q == OW_RUN);
    assign done_o      = done_q;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (N * WI),
        .DEPTH        (2)
    ) i_beat_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (oup_i),
        .push_i  (push),
        .data_o  (mem_wdata_o),
        .pop_i   (pop)
    );

    ita_oup_addr_gen #(
        .N  (N),
        .WI (WI),
        .AW (AW)
    ) i_addr_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .cfg_i  (cfg_i),
        .adv_i  (pop),
        .addr_o (mem_addr_o),
        .last_o (last_beat)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            OW_IDLE: begin
                if (start_i) begin
                    if (job_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = OW_RUN;
                    end
                end
            end
            OW_RUN: begin
                if (pop && last_beat) begin
                    state_d = OW_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = OW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= OW_IDLE;
            done_q    <= 1'b0;
            total_q   <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                total_q   <= 48'(cfg_i.tile_rows) * 48'(cfg_i.tiles_col) * 48'(cfg_i.tiles_row);
                acc_cnt_q <= '0;
            end else if (push) begin
                acc_cnt_q <= acc_cnt_q + 48'd1;
            end
        end
    end

endmodule

// File: tb/tb_ita_oup_writer.sv
// Directed bench for ita_oup_writer: table of jobs with hand-computed address sequences plus
// backpressure, ignored-start and mid-job-reset sequences.
module tb_ita_oup_writer;
    import ita_package::*;

    localparam int unsigned N  = 16;
    localparam int unsigned WI = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = N * WI;

    logic            clk_i       = 1'b0;
    logic            rst_ni      = 1'b0;
    logic            start_i     = 1'b0;
    oup_writer_cfg_t cfg_i       = '0;
    logic            busy_o;
    logic            done_o;
    logic            oup_valid_i = 1'b0;
    logic            oup_ready_o;
    logic [DW-1:0]   oup_i       = '0;
    logic            mem_req_o;
    logic            mem_gnt_i   = 1'b1;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;

    ita_oup_writer #(.N(N), .WI(WI), .AW(AW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .cfg_i       (cfg_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .oup_valid_i (oup_valid_i),
        .oup_ready_o (oup_ready_o),
        .oup_i       (oup_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]      base;
        logic [31:0]      stride;
        logic [15:0]      tr;
        logic [15:0]      tc;
        logic [15:0]      trw;
        int               n;
        logic [7:0][31:0] a;
    } vec_t;

    vec_t vecs [7];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   done_cyc  = -1;
    int   done_cnt  = 0;
    int   req_cnt   = 0;
    int   start_cyc = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    int            acc_cyc_q [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Handshakes are sampled mid-cycle; each record is stamped with the cycle whose edge completes it.
    always @(negedge clk_i) begin
        if (mem_req_o && mem_gnt_i) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_wdata_o);
            wr_cyc_q.push_back(cyc);
        end
        if (mem_req_o) req_cnt++;
        if (oup_valid_i && oup_ready_o) acc_cyc_q.push_back(cyc);
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic vec_t mk(input logic [31:0] base, input logic [31:0] stride,
                                input logic [15:0] tr, input logic [15:0] tc, input logic [15:0] trw,
                                input int n,
                                input logic [31:0] x0 = 32'h0, input logic [31:0] x1 = 32'h0,
                                input logic [31:0] x2 = 32'h0, input logic [31:0] x3 = 32'h0,
                                input logic [31:0] x4 = 32'h0, input logic [31:0] x5 = 32'h0,
                                input logic [31:0] x6 = 32'h0, input logic [31:0] x7 = 32'h0);
        vec_t v;
        v.base = base; v.stride = stride; v.tr = tr; v.tc = tc; v.trw = trw; v.n = n;
        v.a[0] = x0; v.a[1] = x1; v.a[2] = x2; v.a[3] = x3;
        v.a[4] = x4; v.a[5] = x5; v.a[6] = x6; v.a[7] = x7;
        return v;
    endfunction

    function automatic logic [DW-1:0] beat(input int k);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < int'(N); i++) d[i*WI +: WI] = WI'(k * 16 + i + 1);
        return d;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_int({tag, "_busy"}, int'(busy_o), 0);
        chk_int({tag, "_done"}, int'(done_o), 0);
        chk_int({tag, "_ready"}, int'(oup_ready_o), 0);
        chk_int({tag, "_req"}, int'(mem_req_o), 0);
        chk_vec({tag, "_addr"}, DW'(mem_addr_o), '0);
        chk_vec({tag, "_wdata"}, mem_wdata_o, '0);
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
        done_cyc = -1;
        done_cnt = 0;
        req_cnt  = 0;
    endtask

    task automatic start_job(input vec_t v);
        @(posedge clk_i); #1;
        cfg_i = '{base_addr: v.base, row_stride: v.stride, tile_rows: v.tr, tiles_col: v.tc, tiles_row: v.trw};
        start_i   = 1'b1;
        start_cyc = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic stream(input int nbeats, input int gnt_hold, input int mid_start_at, input int stop_after);
        int   sent = 0;
        int   c    = 0;
        logic hs;
        oup_valid_i = 1'b1;
        oup_i       = beat(0);
        mem_gnt_i   = (gnt_hold == 0);
        while (sent < nbeats && c < 300) begin
            @(negedge clk_i);
            hs = oup_valid_i && oup_ready_o;
            if (gnt_hold > 0 && c == gnt_hold - 1) begin
                chk_int("bp_accepted_while_stalled", sent + int'(hs), 2);
                chk_int("bp_ready_low_while_stalled", int'(oup_ready_o), 0);
            end
            @(posedge clk_i); #1;
            c++;
            if (hs) begin
                sent++;
                oup_i = beat(sent);
            end
            mem_gnt_i = (c >= gnt_hold);
            start_i   = (c == mid_start_at);
            if (c == mid_start_at)
                cfg_i = '{base_addr: 32'h9000, row_stride: 32'h10, tile_rows: 16'd1, tiles_col: 16'd1, tiles_row: 16'd1};
            if (stop_after >= 0 && wr_addr_q.size() >= stop_after) return;
        end
        chk_int("beats_sent", sent, nbeats);
        // Keep offering data past the job's beat count; none of it may be accepted.
        repeat (2) @(posedge clk_i);
        #1;
        oup_valid_i = 1'b0;
        start_i     = 1'b0;
        mem_gnt_i   = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input int gnt_hold, input int mid_start_at);
        int w = 0;
        clear_mon();
        start_job(v);
        if (v.n == 0) begin
            repeat (3) @(posedge clk_i);
            #1;
            chk_int("empty_done_cycle", done_cyc, start_cyc + 1);
            chk_int("empty_done_count", done_cnt, 1);
            chk_int("empty_no_req", req_cnt, 0);
            chk_int("empty_busy", int'(busy_o), 0);
            return;
        end
        chk_int("busy_after_start", int'(busy_o), 1);
        stream(v.n, gnt_hold, mid_start_at, -1);
        while (done_cnt == 0 && w < 200) begin
            @(posedge clk_i); #1;
            w++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk_int("done_count", done_cnt, 1);
        chk_int("busy_after_done", int'(busy_o), 0);
        chk_int("write_count", wr_addr_q.size(), v.n);
        chk_int("accept_count", acc_cyc_q.size(), v.n);
        for (int i = 0; i < v.n && i < wr_addr_q.size(); i++) begin
            chk_vec($sformatf("addr[%0d]", i), DW'(wr_addr_q[i]), DW'(v.a[i]));
            chk_vec($sformatf("data[%0d]", i), wr_data_q[i], beat(i));
        end
        if (wr_cyc_q.size() == v.n) begin
            chk_int("done_after_last_grant", done_cyc, wr_cyc_q[v.n-1] + 1);
            if (gnt_hold == 0 && acc_cyc_q.size() > 0) begin
                chk_int("first_beat_latency", wr_cyc_q[0], acc_cyc_q[0] + 1);
                chk_int("back_to_back_writes", wr_cyc_q[v.n-1] - wr_cyc_q[0], v.n - 1);
            end
        end
    endtask

    initial begin
        vecs[0] = mk(32'h1000, 32'd64, 16'd2, 16'd2, 16'd1, 4,
                     32'h1000, 32'h1040, 32'h1010, 32'h1050);
        vecs[1] = mk(32'hFFFF_FFF0, 32'd16, 16'd2, 16'd1, 16'd1, 2,
                     32'hFFFF_FFF0, 32'h0000_0000);
        vecs[2] = mk(32'h2000, 32'h100, 16'd1, 16'd3, 16'd2, 6,
                     32'h2000, 32'h2010, 32'h2020, 32'h2100, 32'h2110, 32'h2120);
        vecs[3] = mk(32'h0, 32'h40, 16'd3, 16'd1, 16'd1, 3,
                     32'h0, 32'h40, 32'h80);
        vecs[4] = mk(32'h4000, 32'h80, 16'd2, 16'd2, 16'd2, 8,
                     32'h4000, 32'h4080, 32'h4010, 32'h4090, 32'h4100, 32'h4180, 32'h4110, 32'h4190);
        vecs[5] = mk(32'h1000, 32'd64, 16'd2, 16'd2, 16'd0, 0);
        vecs[6] = mk(32'h1000, 32'd64, 16'd0, 16'd2, 16'd1, 0);

        repeat (3) @(negedge clk_i);
        chk_outputs_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) run_job(vecs[i], 0, -1);

        // Grant held low for five cycles while beats keep coming.
        run_job(vecs[4], 5, -1);

        // A second start in the middle of a job must be ignored.
        run_job(vecs[0], 0, 1);

        // Reset after three of eight writes, then rerun the same job from its base.
        clear_mon();
        start_job(vecs[4]);
        stream(8, 0, -1, 3);
        chk_int("midjob_writes_before_reset", wr_addr_q.size(), 3);
        oup_valid_i = 1'b0;
        rst_ni      = 1'b0;
        @(negedge clk_i);
        chk_outputs_zero("midjob_reset");
        @(posedge clk_i); #1;
        rst_ni    = 1'b1;
        mem_gnt_i = 1'b1;
        run_job(vecs[4], 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
